// File: rtl/salu_instr_pkg.sv
// ============================================================================
//  Module  : salu_instr_pkg
//  Purpose : Shared SALU/SGPR types used by the issue stages, the SGPR file
//            and the SGPR read-port arbiter.
//  Contents: SGPR_ADDR_W / sgpr_addr_t  - SGPR index width and type
//            SGPR_RD_NUM_REQ / req_idx_t - read-port requester tag type
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package salu_instr_pkg;

  localparam int SGPR_ADDR_W = 7;
  typedef logic [SGPR_ADDR_W-1:0] sgpr_addr_t;

  // Default number of requesters sharing the SGPR read port; the tag type
  // identifies which requester owns an outstanding read.
  localparam int SGPR_RD_NUM_REQ = 4;
  typedef logic [$clog2(SGPR_RD_NUM_REQ)-1:0] req_idx_t;

endpackage : salu_instr_pkg

`default_nettype wire

// File: rtl/sgpr_arb_tag_fifo.sv
// ============================================================================
//  Module  : sgpr_arb_tag_fifo
//  Purpose : Synchronous FIFO of requester tags, one entry per outstanding
//            SGPR read. Push is refused when full, pop ignored when empty.
//  Ports   : clk, rst (async, active-high)
//            push / push_tag  - enqueue a tag
//            pop              - dequeue the head
//            head_tag         - current head entry
//            full, empty, count - registered occupancy status
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sgpr_arb_tag_fifo
  import salu_instr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = $bits(req_idx_t)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [TAG_W-1:0]         push_tag,
  input  logic                     pop,
  output logic [TAG_W-1:0]         head_tag,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [TAG_W-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Status comes from registered occupancy only, so a pop in the same cycle
  // never frees room for a push.
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_tag = storage[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      storage[wr_ptr] <= push_tag;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule : sgpr_arb_tag_fifo

`default_nettype wire

// File: rtl/sgpr_rd_arbiter.sv
// ============================================================================
//  Module  : sgpr_rd_arbiter
//  Purpose : Round-robin arbiter sharing the single SGPR-file read port among
//            NUM_REQ issue stages. A stalled grant is locked until accepted;
//            in-order responses are routed back using a tag FIFO.
//  Ports   : clk, rst (async, active-high)
//            req_valid/req_ready/req_addr          - per-requester requests
//            mem_req_valid/mem_req_ready/mem_req_addr - SGPR file request
//            mem_resp_valid/mem_resp_ready/mem_resp_data - SGPR file response
//            resp_valid/resp_ready/resp_data       - per-requester responses
//            outstanding                           - tag FIFO occupancy
//            err_unexpected_resp                   - sticky stray-response flag
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sgpr_rd_arbiter
  import salu_instr_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_W          = SGPR_ADDR_W,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]          req_addr,
  output logic                               mem_req_valid,
  input  logic                               mem_req_ready,
  output logic [ADDR_W-1:0]                  mem_req_addr,
  input  logic                               mem_resp_valid,
  output logic                               mem_resp_ready,
  input  logic [DATA_W-1:0]                  mem_resp_data,
  output logic [NUM_REQ-1:0]                 resp_valid,
  input  logic [NUM_REQ-1:0]                 resp_ready,
  output logic [DATA_W-1:0]                  resp_data,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_unexpected_resp
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] locked_idx;
  logic             lock;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] head;
  logic             candidate;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  // Grant: locked requester, else first valid requester starting at rr_ptr.
  // The scan runs farthest-first so the closest match is the last write.
  always_comb begin
    grant = rr_ptr;
    if (lock) begin
      grant = locked_idx;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
          grant = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
        end
      end
    end
  end

  assign candidate     = req_valid[grant];
  assign mem_req_valid = candidate && !fifo_full;
  assign mem_req_addr  = req_addr[int'(grant)*ADDR_W +: ADDR_W];
  assign push          = mem_req_valid && mem_req_ready;

  always_comb begin
    req_ready = '0;
    if (mem_req_valid && mem_req_ready) begin
      req_ready[grant] = 1'b1;
    end
  end

  // Responses: route to the FIFO head's owner. With nothing outstanding any
  // arriving response is drained (ready follows valid) and flagged.
  always_comb begin
    resp_valid = '0;
    if (!fifo_empty) begin
      resp_valid[head] = mem_resp_valid;
    end
  end

  assign mem_resp_ready = fifo_empty ? mem_resp_valid : resp_ready[head];
  assign resp_data      = mem_resp_data;
  assign pop            = !fifo_empty && mem_resp_valid && mem_resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr              <= '0;
      lock                <= 1'b0;
      locked_idx          <= '0;
      err_unexpected_resp <= 1'b0;
    end else begin
      // Lock holds the grant steady for as long as the SGPR file stalls it.
      lock <= mem_req_valid && !mem_req_ready;
      if (mem_req_valid && !mem_req_ready) begin
        locked_idx <= grant;
      end
      if (push) begin
        rr_ptr <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
      end
      if (fifo_empty && mem_resp_valid) begin
        err_unexpected_resp <= 1'b1;
      end
    end
  end

  sgpr_arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .TAG_W (IDX_W)
  ) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_tag (grant),
    .pop      (pop),
    .head_tag (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (outstanding)
  );

endmodule : sgpr_rd_arbiter

`default_nettype wire
